exi_capture_ctrl: RTL
=====================

Name: exi_capture_ctrl

Overview:
Sequences the capture DPRAM behind the EXI byte sniffer and shares its single port between capture writes and a host readout path. Stores each EXI transaction as a record: one length byte followed by the payload bytes, in a ring buffer. Only complete records are visible to readout. When a transaction does not fit, the whole transaction is dropped and a sticky flag is set.

Parameters:
ADDR_W, 8, capture RAM address width; depth = 2**ADDR_W bytes
MAX_LEN, 255, maximum payload bytes per record; must be <= 255

Ports:
clk  in  1  system clock (icoboard clock domain)
rst  in  1  synchronous, active-high reset
msg_start  in  1  one-cycle pulse, CS asserted (falling edge seen)
msg_end  in  1  one-cycle pulse, CS deasserted
byte_valid  in  1  one-cycle pulse, byte_data holds a complete MOSI byte
byte_data  in  8  captured byte
ram_cs  out  1  RAM access strobe
ram_wren  out  1  RAM write enable; qualified by ram_cs
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data; valid one cycle after a read strobe
rd_req  in  1  level; host requests the next committed byte
rd_valid  out  1  one-cycle pulse; rd_data valid
rd_data  out  8  byte read out, record format
rd_empty  out  1  no committed unread bytes
overflow  out  1  sticky; set when at least one transaction was dropped
clr_overflow  in  1  clears overflow; set takes priority if both occur in the same cycle

Behaviour:
- Pointers are ADDR_W+1 bits: rd_ptr (next byte to read), commit_ptr (end of committed data), hdr_ptr (reserved length slot), wr_ptr (next payload slot). Addresses are the low ADDR_W bits and wrap naturally.
- Reset values: all pointers 0, state IDLE, cnt 0. Outputs: ram_cs=0, ram_wren=0, rd_valid=0, rd_data=0, overflow=0, rd_empty=1.
- rd_empty = (rd_ptr == commit_ptr).
- used = wr_ptr - rd_ptr, computed modulo 2**(ADDR_W+1). A byte fits when used < depth.
- FSM states: IDLE, CAPT, HDR, DROP.
- IDLE, on msg_start:
  - Reserve the header slot: hdr_ptr = commit_ptr, wr_ptr = commit_ptr + 1, cnt = 0. Go to CAPT.
  - If the header slot does not fit, go to DROP and set overflow.
- CAPT, on byte_valid:
  - If the byte fits and cnt < MAX_LEN, write byte_data at wr_ptr, then increment wr_ptr and cnt.
  - If the byte does not fit, go to DROP and set overflow. wr_ptr is discarded.
  - If cnt == MAX_LEN, ignore the byte (truncation, no flag).
- CAPT, on msg_end:
  - If cnt == 0, discard the record and return to IDLE. commit_ptr is unchanged.
  - Otherwise go to HDR.
- CAPT, msg_start without a prior msg_end: treat as an implicit msg_end. Go through HDR, then start the new record on the following cycle. The start is latched as pending and must not be lost.
- HDR (one cycle): write cnt[7:0] at hdr_ptr, set commit_ptr = wr_ptr, go to IDLE, or to CAPT if a start is pending.
- DROP: ignore bytes. On msg_end return to IDLE. Reset the pending start, commit_ptr unchanged.
- byte_valid and msg_end in the same cycle: write the byte first, then go to HDR on the next cycle. The header includes that byte.
- Arbitration: each cycle the RAM port serves at most one access, in priority order: capture write, HDR write, read.
- Capture bytes arrive at most once every 8 EXI clocks, so reads are never starved indefinitely.
- Read path:
  - When rd_req=1, !rd_empty, no read outstanding, and the port is free: assert a read (ram_cs=1, ram_wren=0, ram_addr=rd_ptr) and increment rd_ptr.
  - On the next cycle, register ram_rdata into rd_data. rd_valid pulses on the cycle after that (2-cycle latency from strobe).
  - At most one read is outstanding.
- rst mid-transaction returns to IDLE and discards all data. No RAM write is issued in the reset cycle.

Decomposition:
- Shared package exi_pkg: state enum (IDLE/CAPT/HDR/DROP), DATA_W=8, record header format constant (HDR_BYTES=1).
- Sub-module exi_ram_arb: fixed-priority single-port mux for write/header/read, plus read-valid pipeline. The FSM and pointers stay in the top module.

Test Plan:
- Single record: start, bytes 0xA5 0x3C, end; then hold rd_req → RAM[0]=0x02, [1]=0xA5, [2]=0x3C; rd_data sequence 02, A5, 3C; then rd_empty=1.
- Empty transaction: start then end with no bytes → commit_ptr stays 0, rd_empty=1, no RAM write.
- Overflow with ADDR_W=4: commit a 14-byte record, then start a second record with 2 bytes, without reading → second record dropped, overflow=1, commit_ptr=15. Readout yields only 15 bytes. clr_overflow clears the flag.
- Wrap: read out, then capture records repeatedly until ptr > 16 with ADDR_W=4 → headers and payload read back correctly across the address wrap.
- Contention: byte_valid coincides with an rd_req read slot, and byte_valid+msg_end occur in the same cycle → write wins, read issued next free cycle, header counts the final byte, no read data corrupted.
- Back-to-back: msg_start arrives in CAPT without msg_end → first record committed via HDR, second record begins at the new commit_ptr; reset asserted mid-CAPT → all pointers 0, rd_empty=1.

Source files
------------

// File: rtl/exi_pkg.sv
// exi_pkg: shared state codes and record-format constants for the EXI capture controller
package exi_pkg;
  localparam int DATA_W = 8;
  localparam int HDR_BYTES = 1;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CAPT = 2'd1;
  localparam state_t HDR = 2'd2;
  localparam state_t DROP = 2'd3;
endpackage

// File: rtl/exi_ram_arb.sv
// exi_ram_arb: fixed-priority single-port RAM mux (capture write > header write > read) with read-data pipeline
module exi_ram_arb
  import exi_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hdr_req,
  input  logic [ADDR_W-1:0] hdr_addr,
  input  logic [DATA_W-1:0] hdr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              ram_cs,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);
  logic wr_go, hdr_go, rd_pend;
  assign wr_go = wr_req & ~rst;
  assign hdr_go = hdr_req & ~rst & ~wr_req;
  // a new read waits until the previous one has been presented on rd_data
  assign rd_grant = rd_req & ~rst & ~wr_req & ~hdr_req & ~rd_pend & ~rd_valid;
  assign ram_cs = wr_go | hdr_go | rd_grant;
  assign ram_wren = wr_go | hdr_go;
  assign ram_addr = wr_go ? wr_addr : hdr_go ? hdr_addr : rd_addr;
  assign ram_wdata = wr_go ? wr_data : hdr_go ? hdr_data : '0;
  always_ff @(posedge clk)
    if (rst) begin
      rd_pend <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_pend <= rd_grant;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= ram_rdata;
    end
endmodule

// File: rtl/exi_capture_ctrl.sv
// exi_capture_ctrl: records EXI transactions as {length, payload} into a ring-buffer RAM and serves host readout
module exi_capture_ctrl
  import exi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_start,
  input  logic              msg_end,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              ram_cs,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              rd_empty,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;
  localparam logic [PW-1:0] HDR_STEP = PW'(HDR_BYTES);
  localparam logic [7:0] CNT_MAX = 8'(MAX_LEN);
  state_t state;
  logic pend, rd_grant, byte_fit, hdr_fit, at_max, byte_ok, byte_bad;
  logic [7:0] cnt, cnt_nx;
  logic [PW-1:0] rd_ptr, commit_ptr, hdr_ptr, wr_ptr;
  assign byte_fit = (wr_ptr - rd_ptr) < DEPTH;
  assign hdr_fit = (commit_ptr - rd_ptr) < DEPTH;
  assign at_max = cnt == CNT_MAX;
  assign byte_ok = state == CAPT && byte_valid && !at_max && byte_fit;
  assign byte_bad = state == CAPT && byte_valid && !at_max && !byte_fit;
  assign cnt_nx = cnt + 8'(byte_ok);
  assign rd_empty = rd_ptr == commit_ptr;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pend <= 1'b0;
      cnt <= '0;
      rd_ptr <= '0;
      commit_ptr <= '0;
      hdr_ptr <= '0;
      wr_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(rd_grant);
      if (clr_overflow) overflow <= 1'b0;
      case (state)
        IDLE:
          if (msg_start) begin
            hdr_ptr <= commit_ptr;
            wr_ptr <= commit_ptr + HDR_STEP;
            cnt <= '0;
            state <= hdr_fit ? CAPT : DROP;
            if (!hdr_fit) overflow <= 1'b1;
          end
        CAPT: begin
          cnt <= cnt_nx;
          wr_ptr <= wr_ptr + PW'(byte_ok);
          if (byte_bad) begin
            overflow <= 1'b1;
            state <= msg_end ? IDLE : DROP;
          end else if (msg_end || msg_start) begin
            // an empty record is discarded; a start on top of it just reuses the reserved slot
            state <= cnt_nx == 8'd0 ? (msg_start ? CAPT : IDLE) : HDR;
            pend <= msg_start && cnt_nx != 8'd0;
          end
        end
        HDR: begin
          commit_ptr <= wr_ptr;
          pend <= 1'b0;
          if (pend || msg_start) begin
            hdr_ptr <= wr_ptr;
            wr_ptr <= wr_ptr + HDR_STEP;
            cnt <= '0;
            state <= byte_fit ? CAPT : DROP;
            if (!byte_fit) overflow <= 1'b1;
          end else state <= IDLE;
        end
        default: begin
          pend <= 1'b0;
          if (msg_end) state <= IDLE;
        end
      endcase
    end
  exi_ram_arb #(.ADDR_W(ADDR_W)) u_arb (
    .clk(clk),
    .rst(rst),
    .wr_req(byte_ok),
    .wr_addr(wr_ptr[ADDR_W-1:0]),
    .wr_data(byte_data),
    .hdr_req(state == HDR),
    .hdr_addr(hdr_ptr[ADDR_W-1:0]),
    .hdr_data(cnt),
    .rd_req(rd_req && !rd_empty),
    .rd_addr(rd_ptr[ADDR_W-1:0]),
    .rd_grant(rd_grant),
    .ram_cs(ram_cs),
    .ram_wren(ram_wren),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .rd_valid(rd_valid),
    .rd_data(rd_data)
  );
endmodule
